// File: rtl/rr_onehot_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant for an 8:3 encoder.
// Optional grant watchdog enabled by `define ARB_TIMEOUT_EN.
module rr_onehot_arbiter_8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;

  logic [15:0] req2;
  logic [7:0]  rot;
  logic [2:0]  off_d;
  logic [2:0]  win_d;
  logic [7:0]  onehot_d;
  logic        rel_d;
  logic        force_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_q;
  logic       timeout_q;
  assign force_d = (wdog_q == WdogLast);
  assign timeout = timeout_q;
`else
  assign force_d = 1'b0;
  assign timeout = 1'b0;
`endif

  // rot[j] is requester (ptr+j) mod 8, so the lowest set bit wins
  always_comb begin
    req2  = {req, req};
    rot   = req2[ptr_q +: 8];
    off_d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off_d = 3'(i);
    end
    win_d    = ptr_q + off_d;
    onehot_d = 8'b1 << win_d;
    rel_d    = ack | ~req[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= onehot_d;
            idx_q   <= win_d;
            valid_q <= 1'b1;
            state_q <= GRANT;
`ifdef ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        GRANT: begin
          if (rel_d || force_d) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + 3'd1;
            state_q <= IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= ~rel_d;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            wdog_q <= wdog_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter_8.sv
// Scoreboard bench for rr_onehot_arbiter_8: directed vectors, queued
// expected grants, negedge monitor with encoder cross-check.
module tb_rr_onehot_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;

  rr_onehot_arbiter_8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] y;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) y = 3'(k);
    end
    return y;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] i);
    exp_t e;
    e.g = g;
    e.i = i;
    q.push_back(e);
  endtask

  // monitor: pops one expected record on every new grant
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
      if (gnt_valid)
        chk("encoder_y", 32'(enc8(gnt)), 32'(gnt_idx));
      if (gnt_valid && !prev_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(e.g));
          chk("sb_idx", 32'(gnt_idx), 32'(e.i));
        end
      end
    end
    prev_valid <= gnt_valid;
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1: asynchronous reset while holding grant 8'h04
    req = 8'h04;
    push(8'h04, 3'd2);
    step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_async_gnt", 32'(gnt), 32'd0);
    chk("t1_async_valid", 32'(gnt_valid), 32'd0);
    req = 8'hFF;
    step();
    chk("t1_hold_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h01, 3'd0);
    step();
    chk("t1_first_gnt", 32'(gnt), 32'h01);

    // T2: rotation with all requests held, ack one cycle after each grant
    for (int k = 1; k <= 8; k++) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("t2_turnaround", 32'(gnt), 32'd0);
      push(8'(1 << (k % 8)), 3'(k % 8));
      step();
    end
    chk("t2_wrap_gnt", 32'(gnt), 32'h01);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 8'h20;
    push(8'h20, 3'd5);
    step();

    // T3: ptr=6 with req=8'h21 wraps to bit 0, then back to bit 5
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 8'h21;
    push(8'h01, 3'd0);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    push(8'h20, 3'd5);
    step();
    chk("t3_second_gnt", 32'(gnt), 32'h20);
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 8'h08;

    // T4: withdrawal releases and moves ptr to 4
    push(8'h08, 3'd3);
    step();
    req = 8'h00;
    step();
    chk("t4_withdraw_gnt", 32'(gnt), 32'd0);
    req = 8'h18;
    push(8'h10, 3'd4);
    step();
    req = 8'h1F;
    step();
    chk("t4_other_bits_ignored", 32'(gnt), 32'h10);

    // T5: ack plus withdrawal together is a single release
    ack = 1'b1;
    req = 8'h60;
    step();
    ack = 1'b0;
    chk("t5_release_gnt", 32'(gnt), 32'd0);
    push(8'h20, 3'd5);
    step();
    ack = 1'b1;
    step();
    req = 8'h00;
    step();
    step();
    chk("t5_idle_ack_gnt", 32'(gnt), 32'd0);
    chk("t5_idle_ack_valid", 32'(gnt_valid), 32'd0);
    ack = 1'b0;
    req = 8'h60;
    push(8'h40, 3'd6);
    step();
    ack = 1'b1;
    req = 8'h00;
    step();
    ack = 1'b0;

    // T6: watchdog behaviour with req=8'h10 held and no ack
    req = 8'h10;
    push(8'h10, 3'd4);
    step();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_hold_gnt", 32'(gnt), 32'h10);
    end
    step();
    chk("t6_forced_gnt", 32'(gnt), 32'd0);
    chk("t6_timeout_pulse", 32'(timeout), 32'd1);
    push(8'h10, 3'd4);
    step();
    chk("t6_regrant", 32'(gnt), 32'h10);
    chk("t6_timeout_low", 32'(timeout), 32'd0);
`else
    begin
      logic held;
      held = 1'b1;
      for (int k = 0; k < 55; k++) begin
        step();
        if (gnt !== 8'h10 || timeout !== 1'b0) held = 1'b0;
      end
      chk("t6_held_no_timeout", 32'(held), 32'd1);
    end
`endif
    ack = 1'b1;
    req = 8'h00;
    step();
    ack = 1'b0;

    begin
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 10) begin
        step();
        budget++;
      end
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
